// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control path.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StRst,
    StFetch,
    StDecode,
    StMemAddr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecR,
    StExecI,
    StWbR,
    StWbI,
    StBranch,
    StJump,
    StHalt
  } ctrl_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_SLT   = 3'b011;
  localparam logic [2:0] ALUOP_LUI   = 3'b100;
  localparam logic [2:0] ALUOP_BNE   = 3'b101;
  localparam logic [2:0] ALUOP_ADD   = 3'b110;
  localparam logic [2:0] ALUOP_OR    = 3'b111;

  // ALU operation for the immediate-arithmetic group.
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    logic [2:0] res;
    case (op)
      OP_SLTI: res = ALUOP_SLT;
      OP_LUI:  res = ALUOP_LUI;
      OP_ORI:  res = ALUOP_OR;
      default: res = ALUOP_ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request waits for its ack and flags expiry on the
// final unacked cycle; an ack in that same cycle suppresses expiry.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic req_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (req_i && !ack_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = req_i && !ack_i && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects, handshakes the shared memory port, counts retirements.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             zero_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             i_or_d_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic             branch_ne_o,
  output logic [1:0]       pc_src_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic             zext_imm_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             illegal_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  ctrl_state_e      state_q, state_d;
  logic [5:0]       op_q;
  logic             illegal_q, timeout_q;
  logic [CNT_W-1:0] cnt_q;
  logic             expire;
  logic             retire;

  // The branch decision itself is resolved in the datapath.
  logic unused_zero;
  assign unused_zero = zero_i;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (state_q != state_d),
    .req_i    (mem_req_o),
    .ack_i    (mem_ack_i),
    .expire_o (expire)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StRst;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRst:     state_d = StFetch;
      StFetch: begin
        if (mem_ack_i)   state_d = StDecode;
        else if (expire) state_d = StHalt;
      end
      StDecode: begin
        case (instr_op_i)
          OP_RTYPE:                         state_d = StExecR;
          OP_ADDI, OP_SLTI, OP_LUI, OP_ORI: state_d = StExecI;
          OP_LW, OP_SW:                     state_d = StMemAddr;
          OP_BEQ, OP_BNE:                   state_d = StBranch;
          OP_J:                             state_d = StJump;
          default:                          state_d = StHalt;
        endcase
      end
      StMemAddr: state_d = (op_q == OP_LW) ? StMemRd : StMemWr;
      StMemRd: begin
        if (mem_ack_i)   state_d = StMemWb;
        else if (expire) state_d = StHalt;
      end
      StMemWr: begin
        if (mem_ack_i)   state_d = StFetch;
        else if (expire) state_d = StHalt;
      end
      StExecR:   state_d = StWbR;
      StExecI:   state_d = StWbI;
      StMemWb, StWbR, StWbI, StBranch, StJump: state_d = StFetch;
      StHalt:    state_d = StHalt;
      default:   state_d = StHalt;
    endcase
  end

  always_comb begin
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    i_or_d_o        = 1'b0;
    ir_write_o      = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    branch_ne_o     = 1'b0;
    pc_src_o        = 2'b00;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    alu_op_o        = 3'b000;
    zext_imm_o      = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = 2'b01;
        alu_op_o    = ALUOP_ADD;
        ir_write_o  = mem_ack_i;
        pc_write_o  = mem_ack_i;
      end
      StDecode: begin
        alu_src_b_o = 2'b11;
        alu_op_o    = ALUOP_ADD;
      end
      StMemAddr: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = ALUOP_ADD;
      end
      StMemRd: begin
        mem_req_o = 1'b1;
        i_or_d_o  = 1'b1;
      end
      StMemWb: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      StMemWr: begin
        mem_req_o = 1'b1;
        i_or_d_o  = 1'b1;
        mem_we_o  = 1'b1;
      end
      StExecR: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALUOP_FUNCT;
      end
      StWbR: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      StExecI, StWbI: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = imm_alu_op(op_q);
        zext_imm_o  = (op_q == OP_ORI);
        reg_write_o = (state_q == StWbI);
      end
      StBranch: begin
        alu_src_a_o     = 1'b1;
        pc_write_cond_o = 1'b1;
        pc_src_o        = 2'b01;
        branch_ne_o     = (op_q == OP_BNE);
        alu_op_o        = (op_q == OP_BNE) ? ALUOP_BNE : ALUOP_SUB;
      end
      StJump: begin
        pc_write_o = 1'b1;
        pc_src_o   = 2'b10;
      end
      default: ;
    endcase
  end

  assign retire = (state_d == StFetch) &&
                  (state_q inside {StMemWb, StMemWr, StWbR, StWbI, StBranch, StJump});

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q      <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (state_q == StDecode) begin
        op_q <= instr_op_i;
      end
      if (state_q == StDecode && state_d == StHalt) begin
        illegal_q <= 1'b1;
      end
      if (expire) begin
        timeout_q <= 1'b1;
      end
      if (retire) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign illegal_o   = illegal_q;
  assign timeout_o   = timeout_q;
  assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control words checked against
// hand-written expectations for each instruction class, timeout and reset.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  instr_op;
  logic        zero;
  logic        mem_ack;
  logic        mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne;
  logic [1:0]  pc_src, alu_src_b;
  logic        alu_src_a, zext_imm, reg_dst, mem_to_reg, reg_write;
  logic [2:0]  alu_op;
  logic        illegal, timeout;
  logic [31:0] instr_cnt;
  logic [18:0] ctl;

  int n_checks = 0;
  int n_errors = 0;

  // Fields: req we iord irw pcw pcwc bne | pc_src | src_a | src_b | alu_op | zext rdst m2r rw
  localparam logic [18:0] C_IDLE    = 19'b0000000_00_0_00_000_0000;
  localparam logic [18:0] C_FETCH_W = 19'b1000000_00_0_01_110_0000;
  localparam logic [18:0] C_FETCH_A = 19'b1001100_00_0_01_110_0000;
  localparam logic [18:0] C_DECODE  = 19'b0000000_00_0_11_110_0000;
  localparam logic [18:0] C_MADDR   = 19'b0000000_00_1_10_110_0000;
  localparam logic [18:0] C_MEMRD   = 19'b1010000_00_0_00_000_0000;
  localparam logic [18:0] C_MEMWB   = 19'b0000000_00_0_00_000_0011;
  localparam logic [18:0] C_MEMWR   = 19'b1110000_00_0_00_000_0000;
  localparam logic [18:0] C_EXECR   = 19'b0000000_00_1_00_010_0000;
  localparam logic [18:0] C_WBR     = 19'b0000000_00_0_00_000_0101;
  localparam logic [18:0] C_EXORI   = 19'b0000000_00_1_10_111_1000;
  localparam logic [18:0] C_WBORI   = 19'b0000000_00_1_10_111_1001;
  localparam logic [18:0] C_BNE     = 19'b0000011_01_1_00_101_0000;
  localparam logic [18:0] C_JUMP    = 19'b0000100_10_0_00_000_0000;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BNE = 6'b000101, OP_ORI = 6'b001101, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  multicycle_ctrl #(
    .TIMEOUT (16),
    .CNT_W   (32)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .instr_op_i      (instr_op),
    .zero_i          (zero),
    .mem_ack_i       (mem_ack),
    .mem_req_o       (mem_req),
    .mem_we_o        (mem_we),
    .i_or_d_o        (i_or_d),
    .ir_write_o      (ir_write),
    .pc_write_o      (pc_write),
    .pc_write_cond_o (pc_write_cond),
    .branch_ne_o     (branch_ne),
    .pc_src_o        (pc_src),
    .alu_src_a_o     (alu_src_a),
    .alu_src_b_o     (alu_src_b),
    .alu_op_o        (alu_op),
    .zext_imm_o      (zext_imm),
    .reg_dst_o       (reg_dst),
    .mem_to_reg_o    (mem_to_reg),
    .reg_write_o     (reg_write),
    .illegal_o       (illegal),
    .timeout_o       (timeout),
    .instr_cnt_o     (instr_cnt)
  );

  always #5 clk = ~clk;

  assign ctl = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne,
                pc_src, alu_src_a, alu_src_b, alu_op, zext_imm, reg_dst, mem_to_reg,
                reg_write};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock cycle: called at a negedge, drives inputs, checks, moves to next negedge.
  task automatic cyc(input logic ack, input logic [5:0] op, input string tag,
                     input logic [18:0] exp);
    mem_ack  = ack;
    instr_op = op;
    #1;
    check(tag, {13'b0, ctl}, {13'b0, exp});
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; mem_ack = 1'b0; instr_op = OP_R; zero = 1'b0;
    @(negedge clk);
    check("reset_ctl", {13'b0, ctl}, 32'd0);
    check("reset_cnt", instr_cnt, 32'd0);
    check("reset_flags", {30'b0, illegal, timeout}, 32'd0);
    rst = 1'b1;

    // R-type
    cyc(1'b0, OP_R, "r_rst", C_IDLE);
    cyc(1'b1, OP_R, "r_fetch", C_FETCH_A);
    cyc(1'b0, OP_R, "r_decode", C_DECODE);
    cyc(1'b1, OP_R, "r_exec", C_EXECR);
    cyc(1'b0, OP_R, "r_wb", C_WBR);
    check("r_cnt", instr_cnt, 32'd1);

    // lw with ack on the 4th request cycle
    cyc(1'b1, OP_LW, "lw_fetch", C_FETCH_A);
    cyc(1'b0, OP_LW, "lw_decode", C_DECODE);
    cyc(1'b0, OP_LW, "lw_addr", C_MADDR);
    for (int i = 0; i < 3; i++) cyc(1'b0, OP_LW, "lw_rd_wait", C_MEMRD);
    cyc(1'b1, OP_LW, "lw_rd_ack", C_MEMRD);
    cyc(1'b0, OP_LW, "lw_wb", C_MEMWB);
    check("lw_cnt", instr_cnt, 32'd2);

    // bne
    cyc(1'b1, OP_BNE, "bne_fetch", C_FETCH_A);
    cyc(1'b0, OP_BNE, "bne_decode", C_DECODE);
    cyc(1'b0, OP_BNE, "bne_branch", C_BNE);
    check("bne_cnt", instr_cnt, 32'd3);

    // ori
    cyc(1'b1, OP_ORI, "ori_fetch", C_FETCH_A);
    cyc(1'b0, OP_ORI, "ori_decode", C_DECODE);
    cyc(1'b0, OP_ORI, "ori_exec", C_EXORI);
    cyc(1'b0, OP_ORI, "ori_wb", C_WBORI);
    check("ori_cnt", instr_cnt, 32'd4);

    // sw, acked immediately
    cyc(1'b1, OP_SW, "sw_fetch", C_FETCH_A);
    cyc(1'b0, OP_SW, "sw_decode", C_DECODE);
    cyc(1'b0, OP_SW, "sw_addr", C_MADDR);
    cyc(1'b1, OP_SW, "sw_wr", C_MEMWR);
    check("sw_cnt", instr_cnt, 32'd5);

    // jump
    cyc(1'b1, OP_J, "j_fetch", C_FETCH_A);
    cyc(1'b0, OP_J, "j_decode", C_DECODE);
    cyc(1'b0, OP_J, "j_jump", C_JUMP);
    check("j_cnt", instr_cnt, 32'd6);

    // illegal opcode: halt, ack ignored, no further requests
    cyc(1'b1, OP_BAD, "ill_fetch", C_FETCH_A);
    cyc(1'b0, OP_BAD, "ill_decode", C_DECODE);
    for (int i = 0; i < 3; i++) cyc(1'b1, OP_BAD, "ill_halt", C_IDLE);
    check("ill_flag", {31'b0, illegal}, 32'd1);
    check("ill_cnt", instr_cnt, 32'd6);
    rst = 1'b0;
    #1;
    check("ill_rst_flag", {31'b0, illegal}, 32'd0);
    check("ill_rst_cnt", instr_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // fetch timeout: 16 unacked cycles
    cyc(1'b0, OP_R, "to_rst", C_IDLE);
    for (int i = 0; i < 16; i++) cyc(1'b0, OP_R, "to_fetch", C_FETCH_W);
    mem_ack = 1'b1;
    #1;
    check("to_halt_ctl", {13'b0, ctl}, 32'd0);
    check("to_flag", {31'b0, timeout}, 32'd1);
    check("to_no_illegal", {31'b0, illegal}, 32'd0);
    @(negedge clk);
    cyc(1'b1, OP_R, "to_halt_hold", C_IDLE);
    rst = 1'b0;
    #1;
    check("to_rst_flag", {31'b0, timeout}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // ack on the 16th cycle wins over the timeout
    cyc(1'b0, OP_SW, "ta_rst", C_IDLE);
    for (int i = 0; i < 15; i++) cyc(1'b0, OP_SW, "ta_fetch", C_FETCH_W);
    cyc(1'b1, OP_SW, "ta_fetch_ack", C_FETCH_A);
    cyc(1'b0, OP_SW, "ta_decode", C_DECODE);
    check("ta_flag", {31'b0, timeout}, 32'd0);
    cyc(1'b0, OP_SW, "ta_addr", C_MADDR);

    // asynchronous reset mid-MEM_WR drops the request before the next edge
    mem_ack = 1'b0;
    #1;
    check("ar_req_before", {31'b0, mem_req}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_req_after", {31'b0, mem_req}, 32'd0);
    check("ar_ctl_after", {13'b0, ctl}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, OP_R, "ar_rst", C_IDLE);
    cyc(1'b0, OP_R, "ar_fetch", C_FETCH_W);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
